palette_loader: RTL and testbench

- Sequences runtime loads of the 64-entry, 24-bit user palette RAM inside the video block.
- Accepts a byte stream from the data-slot/bridge side with a valid/ready handshake and packs every 3 bytes (R, G, B) into one entry.
- Issues single-cycle load_color writes, gated to vertical blank so the visible frame is not corrupted.
- Reports busy, done and abort status to the core's control logic.

---
 rtl/palette_loader.sv | 134 +++++++++++++
 tb/tb_palette_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_loader.sv
// Palette RAM loader: packs an R,G,B byte stream into 24-bit entries and issues
// vblank-gated load_color writes. Define PAL_LOADER_CHECKSUM_EN to add the byte-sum output.
module palette_loader #(
    parameter int unsigned ENTRIES    = 64,
    parameter int unsigned INDEX_W    = 6,
    parameter int unsigned BLANK_GATE = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    input  logic               vblank,
    output logic               load_color,
    output logic [23:0]        load_color_data,
    output logic [INDEX_W-1:0] load_color_index,
    output logic               busy,
    output logic               done,
    output logic               abort
`ifdef PAL_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]         checksum
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WAIT_BLANK,
        WRITE,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [INDEX_W-1:0] index;
    logic [1:0]         phase;
    logic [23:0]        assembly;
    logic               xfer;
    logic               last_entry;
    logic               in_load;

    assign xfer       = byte_valid && byte_ready;
    assign last_entry = (index == INDEX_W'(ENTRIES - 1));
    assign in_load    = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = COLLECT;
            COLLECT: begin
                if (start)                      state_next = COLLECT;
                else if (xfer && phase == 2'd2) state_next = WAIT_BLANK;
            end
            WAIT_BLANK: begin
                if (start)                           state_next = COLLECT;
                else if (vblank || BLANK_GATE == 0)  state_next = WRITE;
            end
            WRITE: begin
                if (start)           state_next = COLLECT;
                else if (last_entry) state_next = DONE;
                else                 state_next = COLLECT;
            end
            DONE:       state_next = start ? COLLECT : IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == COLLECT);
        load_color = (state == WRITE);
        done       = (state == DONE);
        busy       = in_load;
    end

    // A start wins over a byte landing on the same edge: the partial entry is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            index            <= '0;
            phase            <= '0;
            assembly         <= '0;
            abort            <= 1'b0;
            load_color_data  <= '0;
            load_color_index <= '0;
`ifdef PAL_LOADER_CHECKSUM_EN
            checksum         <= '0;
`endif
        end else begin
            abort <= 1'b0;
            if (start) begin
                index    <= '0;
                phase    <= '0;
                assembly <= '0;
                abort    <= in_load;
`ifdef PAL_LOADER_CHECKSUM_EN
                checksum <= '0;
`endif
            end else begin
                case (state)
                    COLLECT: begin
                        if (xfer) begin
                            case (phase)
                                2'd0:    assembly[23:16] <= byte_data;
                                2'd1:    assembly[15:8]  <= byte_data;
                                default: assembly[7:0]   <= byte_data;
                            endcase
                            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
`ifdef PAL_LOADER_CHECKSUM_EN
                            checksum <= checksum + byte_data;
`endif
                        end
                    end
                    WRITE: if (!last_entry) index <= index + 1'b1;
                    default: ;
                endcase
            end
            // Separate output registers keep data/index steady after the index advances.
            if (state == WAIT_BLANK && state_next == WRITE) begin
                load_color_data  <= assembly;
                load_color_index <= index;
            end
        end
    end

endmodule

// File: tb/tb_palette_loader.sv
// Directed self-checking bench for palette_loader: a cycle table for the first
// entry, then hand-written sequences for full load, gating, backpressure, restart and reset.
module tb_palette_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        vblank;
    logic        load_color;
    logic [23:0] load_color_data;
    logic [5:0]  load_color_index;
    logic        busy;
    logic        done;
    logic        abort;
`ifdef PAL_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    palette_loader #(.ENTRIES(64), .INDEX_W(6), .BLANK_GATE(1)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_ready       (byte_ready),
        .vblank           (vblank),
        .load_color       (load_color),
        .load_color_data  (load_color_data),
        .load_color_index (load_color_index),
        .busy             (busy),
        .done             (done),
        .abort            (abort)
`ifdef PAL_LOADER_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          idx;
        logic [23:0] data;
        int          cyc;
    } wr_t;

    wr_t  wr_q[$];
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    logic done_busy = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (load_color) wr_q.push_back('{int'(load_color_index), load_color_data, cyc});
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        tick();
        tick();
        reset_n = 1'b1;
        clear_mon();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 200) begin
            tick();
            t++;
        end
        if (!byte_ready) check("byte_accept_timeout", 64'(byte_ready), 64'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_q.size() < n && t < 300) begin
            tick();
            t++;
        end
        check("write_seen", 64'(wr_q.size() >= n), 64'd1);
    endtask

    function automatic logic [7:0] exp_byte(input int mode, input int i);
        case (mode)
            0:       return (i < 3) ? 8'h66 : 8'(i * 7 + 5);
            1:       return 8'(i + 1);
            default: return 8'h01;
        endcase
    endfunction

    task automatic run_load(input int mode, input bit gaps);
        int t;
        pulse_start();
        for (int i = 0; i < 192; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            send_byte(exp_byte(mode, i));
        end
        t = 0;
        while (done_cnt == 0 && t < 50) begin
            tick();
            t++;
        end
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        check("write_count", 64'(wr_q.size()), 64'd64);
        for (int k = 0; k < 64 && k < wr_q.size(); k++) begin
            check($sformatf("entry_%0d", k), {8'(wr_q[k].idx), wr_q[k].data},
                  {8'(k), exp_byte(mode, 3*k), exp_byte(mode, 3*k+1), exp_byte(mode, 3*k+2)});
        end
        if (wr_q.size() == 64) check("done_after_last_write", 64'(done_cyc), 64'(wr_q[63].cyc + 1));
        check("busy_low_at_done", 64'(done_busy), 64'd0);
    endtask

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        vblank;
        logic        ready;
        logic        load;
        logic        busy;
        logic        done;
        logic        abort;
        logic [5:0]  idx;
        logic [23:0] ldata;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int bad;
        int t;
        //          start valid data   vbl  rdy  ld  bsy dn  ab  idx  data
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 24'h000000};
        tbl[1] = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 24'h000000};
        tbl[2] = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 24'h000000};
        tbl[3] = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 24'h000000};
        tbl[4] = '{1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 24'h666666};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 24'h666666};

        vblank = 1'b1;
        do_reset();
        check("reset_outputs",
              {byte_ready, load_color, busy, done, abort, load_color_index, load_color_data},
              {5'b00000, 6'd0, 24'd0});

        for (int r = 0; r < 6; r++) begin
            start      = tbl[r].start;
            byte_valid = tbl[r].valid;
            byte_data  = tbl[r].data;
            vblank     = tbl[r].vblank;
            tick();
            check($sformatf("table_row_%0d", r),
                  {byte_ready, load_color, busy, done, abort, load_color_index, load_color_data},
                  {tbl[r].ready, tbl[r].load, tbl[r].busy, tbl[r].done, tbl[r].abort,
                   tbl[r].idx, tbl[r].ldata});
        end
        start = 1'b0;
        byte_valid = 1'b0;

        // Full back-to-back load
        do_reset();
        run_load(0, 1'b0);
        byte_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            tick();
            if (byte_ready) bad++;
        end
        byte_valid = 1'b0;
        check("no_accept_after_done", 64'(bad), 64'd0);
        check("single_done_pulse", 64'(done_cnt), 64'd1);

        // Vblank gating on entry 5
        do_reset();
        vblank = 1'b1;
        pulse_start();
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        t = 0;
        while (!byte_ready && t < 20) begin
            tick();
            t++;
        end
        vblank = 1'b0;
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        bad = 0;
        repeat (20) begin
            tick();
            if (load_color || byte_ready) bad++;
        end
        check("gated_hold", 64'(bad), 64'd0);
        vblank = 1'b1;
        tick();
        check("gated_release", {load_color, load_color_index, load_color_data}, {1'b1, 6'd5, 24'hA1B2C3});

        // Backpressure with random gaps
        do_reset();
        run_load(1, 1'b1);

        // Restart mid-entry 10, phase 1
        do_reset();
        pulse_start();
        for (int i = 0; i < 31; i++) send_byte(8'(i + 1));
        check("pre_restart_writes", 64'(wr_q.size()), 64'd10);
        pulse_start();
        check("abort_pulse", {abort, busy, byte_ready}, {1'b1, 1'b1, 1'b1});
        tick();
        check("abort_one_cycle", 64'(abort), 64'd0);
        clear_mon();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        wait_writes(1);
        if (wr_q.size() > 0)
            check("restart_first_write", {8'(wr_q[0].idx), wr_q[0].data}, {8'd0, 24'hAABBCC});

        // Reset during the write of entry 3
        do_reset();
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(8'(i + 16));
        t = 0;
        while (!(load_color && load_color_index == 6'd3) && t < 20) begin
            tick();
            t++;
        end
        check("write3_reached", {load_color, load_color_index}, {1'b1, 6'd3});
        reset_n = 1'b0;
        tick();
        check("reset_mid_write",
              {byte_ready, load_color, busy, done, abort, load_color_index, load_color_data},
              {5'b00000, 6'd0, 24'd0});
        reset_n = 1'b1;
        clear_mon();
        tick();
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_writes(1);
        if (wr_q.size() > 0)
            check("post_reset_first_write", {8'(wr_q[0].idx), wr_q[0].data}, {8'd0, 24'h112233});

`ifdef PAL_LOADER_CHECKSUM_EN
        do_reset();
        run_load(2, 1'b0);
        check("checksum_at_done", 64'(checksum), 64'hC0);
        tick();
        check("checksum_stable", 64'(checksum), 64'hC0);
        pulse_start();
        check("checksum_cleared", 64'(checksum), 64'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1);
    end

endmodule
